neuron_layer_engine: RTL and testbench
======================================

NEURON_LAYER_ENGINE -- requirements
Module: neuron_layer_engine

Interface
REQ-001 The module SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameter N_NEURONS, default 4: neurons evaluated per run, range 1..64.
REQ-003 Parameter N_INPUTS, default 8: inputs per neuron, range 1..64.
REQ-004 Parameter DATA_W, default 16: signed fixed-point width of inputs, weights and outputs.
REQ-005 Parameter FRAC_W, default 8: fractional bits of the fixed-point format.
REQ-006 Parameter ADDR_W, default 9: BRAM word-address width.
REQ-007 Port clk, input, 1: sole clock, rising edge.
REQ-008 Port rst, input, 1: asynchronous active-high reset.
REQ-009 Port start, input, 1: single-cycle run request.
REQ-010 Port act_mode, input, 1: activation select, 0 = step, 1 = ReLU; sampled on accepted start.
REQ-011 Ports in_base, w_base, out_base, input, ADDR_W each: region base addresses; sampled on accepted start.
REQ-012 Port busy, output, 1: run in progress.
REQ-013 Port done, output, 1: one-cycle pulse at run end.
REQ-014 Port sat_flag, output, 1: some neuron saturated during the last run.
REQ-015 Port bram_enable, output, 1: BRAM port enable.
REQ-016 Port bram_write_enable_bytes, output, 4: byte write enables.
REQ-017 Port bram_data_addr, output, ADDR_W: BRAM address.
REQ-018 Port bram_data_out, output, 32: write data to BRAM.
REQ-019 Port bram_data_in, input, 32: read data from BRAM, valid one cycle after the enabled read.

Function
REQ-020 Memory layout SHALL be: input i at in_base+i; weight (n,i) at w_base+n*STRIDE+i; output n at out_base+n. STRIDE=N_INPUTS (+1 with bias). All values occupy bits [DATA_W-1:0]; address arithmetic wraps modulo 2^ADDR_W.
REQ-021 FSM states SHALL be IDLE, LOAD, MAC, DRAIN, WRITE, DONE.
REQ-022 IDLE: start=1 SHALL latch the configuration, clear sat_flag, assert busy and enter LOAD; start while busy SHALL be ignored.
REQ-023 LOAD SHALL read the N_INPUTS inputs on consecutive cycles into an internal input register file.
REQ-024 MAC SHALL issue one weight read per cycle; each returned weight is multiplied by the cached input into a full 2*DATA_W signed product and added to an accumulator widened by clog2(N_INPUTS+1) guard bits.
REQ-025 DRAIN SHALL absorb the final read-latency cycle; WRITE SHALL then write one word with bram_write_enable_bytes=4'b0011 and bits [31:DATA_W] zero.
REQ-026 The result SHALL be accumulator arithmetic-shifted right by FRAC_W, then saturated to the signed DATA_W range; a clamp SHALL set sat_flag.
REQ-027 Activation: step SHALL output 1<<FRAC_W if the result is >=0, else 0; ReLU SHALL output max(result,0).
REQ-028 After the last neuron's WRITE, DONE SHALL pulse done for one cycle, drop busy and return to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-029 Run length SHALL be exactly (N_INPUTS+1) + N_NEURONS*(STRIDE+2) cycles from the start cycle to the done cycle.
REQ-030 bram_enable SHALL be high only on read and write cycles; bram_write_enable_bytes SHALL be 0 on reads.

Reset
REQ-031 Reset SHALL force IDLE; busy, done, sat_flag, bram_enable, bram_write_enable_bytes, bram_data_addr, bram_data_out and the accumulator SHALL all be 0.
REQ-032 Reset mid-run SHALL abort immediately, with no further BRAM access.

Configuration
REQ-033 With NEURON_LAYER_BIAS_EN defined, each neuron SHALL read one extra word at w_base+n*STRIDE+N_INPUTS as the first MAC read and seed the accumulator with bias<<FRAC_W.
REQ-034 Without NEURON_LAYER_BIAS_EN, the accumulator SHALL start each neuron at 0 and STRIDE SHALL equal N_INPUTS.

Structure
REQ-035 A shared package neuron_pkg SHALL hold the FSM state encoding, the act_mode constants and the accumulator-width function.
REQ-036 Multiply, accumulate, shift, saturate and activation SHALL live in sub-module neuron_mac.

Verification (N_NEURONS=4, N_INPUTS=8, FRAC_W=8, bias off unless stated)
REQ-037 Inputs all 0x0100, neuron 0 weights all 0x0100, step -> out_base+0 = 0x0100, done exactly 49 cycles after start.
REQ-038 Neuron 1 weights all 0xFF00 (-1.0), ReLU -> word 0x00000000; step -> 0x00000000.
REQ-039 Inputs 0x7FFF, weights 0x7FFF, ReLU -> 0x7FFF and sat_flag=1 until the next start.
REQ-040 Bias on, bias 0x0200, weights 0, ReLU -> 0x0200 per neuron, run length 53 cycles.
REQ-041 Reset asserted during MAC of neuron 2 -> busy=0 and bram_enable=0 immediately; a fresh start then completes correctly.
REQ-042 start pulsed while busy, and in the DONE cycle -> ignored; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron layer engine: FSM state encoding,
// activation-mode constants and the accumulator width helper.
package neuron_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic ACT_STEP = 1'b0;
  localparam logic ACT_RELU = 1'b1;

  // Counter width: large enough for 64 inputs plus an optional bias word.
  localparam int CNT_W = 7;

  // Full signed product plus enough guard bits to sum N_INPUTS products
  // (and a bias) without wrapping.
  function automatic int acc_width(input int data_w, input int n_inputs);
    return 2 * data_w + $clog2(n_inputs + 1);
  endfunction

endpackage

// File: rtl/neuron_layer_engine_if.sv
// Single-port BRAM bus between the engine (master) and the memory (slave).
// No handshake: bram_enable qualifies a cycle; a write happens when
// bram_write_enable_bytes is non-zero, otherwise it is a read whose data
// appears on bram_data_in exactly one cycle later.
interface neuron_layer_engine_if #(
  parameter int ADDR_W = 9
);
  logic              bram_enable;
  logic [3:0]        bram_write_enable_bytes;
  logic [ADDR_W-1:0] bram_data_addr;
  logic [31:0]       bram_data_out;
  logic [31:0]       bram_data_in;

  modport master (
    output bram_enable, bram_write_enable_bytes, bram_data_addr, bram_data_out,
    input  bram_data_in
  );

  modport slave (
    input  bram_enable, bram_write_enable_bytes, bram_data_addr, bram_data_out,
    output bram_data_in
  );
endinterface

// File: rtl/neuron_mac.sv
// Datapath for one neuron: signed multiply-accumulate, fixed-point
// rescale, saturation and activation. The result is combinational from the
// accumulator so it is ready in the cycle after the last accumulate.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int N_INPUTS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,       // bram data holds a weight or bias
  input  logic                     first_i,    // first word of a neuron: restart sum
  input  logic                     seed_i,     // word is a bias, not a weight
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic                     act_mode_i,
  output logic        [DATA_W-1:0] act_o,
  output logic                     sat_o
);

  localparam int ACC_W = acc_width(DATA_W, N_INPUTS);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE_V = DATA_W'(1) << FRAC_W;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d, acc_base, shifted;
  logic signed [DATA_W-1:0]   res;

  assign prod = w_i * x_i;

  // Next accumulator value: restart on the first word, bias is pre-scaled.
  always_comb begin
    acc_d    = acc_q;
    acc_base = first_i ? '0 : acc_q;
    if (en_i) begin
      if (seed_i) begin
        acc_d = acc_base + ({{(ACC_W-DATA_W){w_i[DATA_W-1]}}, w_i} <<< FRAC_W);
      end else begin
        acc_d = acc_base + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      end
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Rescale, clamp to the signed output range, then apply the activation.
  always_comb begin
    shifted = acc_q >>> FRAC_W;
    sat_o   = 1'b0;
    res     = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      res   = {1'b0, {(DATA_W-1){1'b1}}};
      sat_o = 1'b1;
    end else if (shifted < MIN_V) begin
      res   = {1'b1, {(DATA_W-1){1'b0}}};
      sat_o = 1'b1;
    end
    if (act_mode_i == ACT_RELU) begin
      act_o = res[DATA_W-1] ? '0 : res;
    end else begin
      act_o = res[DATA_W-1] ? '0 : ONE_V;
    end
  end

endmodule

// File: rtl/neuron_layer_engine.sv
// Fully-connected layer engine: loads N_INPUTS inputs from BRAM, then for
// each neuron streams its weights through neuron_mac and writes the
// activated result back. Define NEURON_LAYER_BIAS_EN to give each neuron a
// bias word stored after its weights and read first.
// start is a one-cycle request, accepted only in IDLE and ignored otherwise.
module neuron_layer_engine
  import neuron_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 8,
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              act_mode,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              busy,
  output logic              done,
  output logic              sat_flag,
  output state_t            state_o,
  neuron_layer_engine_if.master bram
);

`ifdef NEURON_LAYER_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  localparam int STRIDE = N_INPUTS + (BIAS_EN ? 1 : 0);
  localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, n_q, n_d, ld_idx_q, ld_idx_d, rd_idx_q, rd_idx_d;
  logic              ld_vld_q, ld_vld_d, rd_vld_q, rd_vld_d, act_q, act_d, sat_q, sat_d;
  logic [ADDR_W-1:0] in_ptr_q, in_ptr_d, row_q, row_d, out_ptr_q, out_ptr_d;
  logic [DATA_W-1:0] xreg_q [0:(1<<IDX_W)-1];
  logic [ADDR_W-1:0] w_off;
  logic [CNT_W-1:0]  x_sel;
  logic [DATA_W-1:0] mac_out;
  logic              mac_sat, mac_first, mac_seed;
  logic              unused_bits;

  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign sat_flag = sat_q;
  assign state_o  = state_q;

  assign unused_bits = ^{bram.bram_data_in[31:DATA_W], ld_idx_q[CNT_W-1:IDX_W],
                         x_sel[CNT_W-1:IDX_W]};

  // Map read counters to weight-row offsets and cached-input indices; with a
  // bias the first read of a row fetches the word stored after its weights.
  always_comb begin
    mac_first = (rd_idx_q == '0);
    if (BIAS_EN) begin
      w_off    = (cnt_q == '0) ? ADDR_W'(N_INPUTS) : ADDR_W'(cnt_q - CNT_W'(1));
      x_sel    = rd_idx_q - CNT_W'(1);
      mac_seed = mac_first;
    end else begin
      w_off    = ADDR_W'(cnt_q);
      x_sel    = rd_idx_q;
      mac_seed = 1'b0;
    end
  end

  // Next-state logic and BRAM bus drive.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    act_d     = act_q;
    sat_d     = sat_q;
    in_ptr_d  = in_ptr_q;
    row_d     = row_q;
    out_ptr_d = out_ptr_q;
    ld_vld_d  = 1'b0;
    ld_idx_d  = cnt_q;
    rd_vld_d  = 1'b0;
    rd_idx_d  = cnt_q;
    bram.bram_enable             = 1'b0;
    bram.bram_write_enable_bytes = 4'b0000;
    bram.bram_data_addr          = '0;
    bram.bram_data_out           = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          act_d     = act_mode;
          sat_d     = 1'b0;
          in_ptr_d  = in_base;
          row_d     = w_base;
          out_ptr_d = out_base;
          cnt_d     = '0;
          n_d       = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        bram.bram_enable    = 1'b1;
        bram.bram_data_addr = in_ptr_q;
        ld_vld_d            = 1'b1;
        in_ptr_d            = in_ptr_q + ADDR_W'(1);
        if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
          cnt_d   = '0;
          state_d = MAC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MAC: begin
        bram.bram_enable    = 1'b1;
        bram.bram_data_addr = row_q + w_off;
        rd_vld_d            = 1'b1;
        if (cnt_q == CNT_W'(STRIDE - 1)) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        state_d = WRITE;
      end
      WRITE: begin
        bram.bram_enable             = 1'b1;
        bram.bram_write_enable_bytes = 4'b0011;
        bram.bram_data_addr          = out_ptr_q;
        bram.bram_data_out           = 32'(mac_out);
        out_ptr_d                    = out_ptr_q + ADDR_W'(1);
        if (mac_sat) sat_d = 1'b1;
        if (n_q == CNT_W'(N_NEURONS - 1)) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + CNT_W'(1);
          cnt_d   = '0;
          row_d   = row_q + ADDR_W'(STRIDE);
          state_d = MAC;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      act_q     <= ACT_STEP;
      sat_q     <= 1'b0;
      in_ptr_q  <= '0;
      row_q     <= '0;
      out_ptr_q <= '0;
      ld_vld_q  <= 1'b0;
      ld_idx_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      act_q     <= act_d;
      sat_q     <= sat_d;
      in_ptr_q  <= in_ptr_d;
      row_q     <= row_d;
      out_ptr_q <= out_ptr_d;
      ld_vld_q  <= ld_vld_d;
      ld_idx_q  <= ld_idx_d;
      rd_vld_q  <= rd_vld_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  // Input cache, filled as the LOAD reads return.
  always_ff @(posedge clk) begin
    if (ld_vld_q) xreg_q[ld_idx_q[IDX_W-1:0]] <= bram.bram_data_in[DATA_W-1:0];
  end

  neuron_mac #(
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .N_INPUTS (N_INPUTS)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .en_i       (rd_vld_q),
    .first_i    (mac_first),
    .seed_i     (mac_seed),
    .w_i        (bram.bram_data_in[DATA_W-1:0]),
    .x_i        (xreg_q[x_sel[IDX_W-1:0]]),
    .act_mode_i (act_q),
    .act_o      (mac_out),
    .sat_o      (mac_sat)
  );

endmodule

// File: tb/tb_neuron_layer_engine.sv
// Self-checking bench for neuron_layer_engine with a behavioural BRAM and
// an arithmetic reference model of the layer.
`timescale 1ns/1ps
module tb_neuron_layer_engine;
  import neuron_pkg::*;

  localparam int NN = 4, NI = 8, DW = 16, FW = 8, AW = 9;
`ifdef NEURON_LAYER_BIAS_EN
  localparam int STRIDE = NI + 1;
  localparam bit BIAS = 1'b1;
`else
  localparam int STRIDE = NI;
  localparam bit BIAS = 1'b0;
`endif
  localparam int RUN_LEN = (NI + 1) + NN * (STRIDE + 2);
  localparam int MEM_N = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, act_mode = 1'b0;
  logic [AW-1:0] in_base = '0, w_base = '0, out_base = '0;
  logic busy, done, sat_flag;
  state_t state_dbg;
  always #5 clk = ~clk;

  neuron_layer_engine_if #(.ADDR_W(AW)) bus ();

  neuron_layer_engine #(.N_NEURONS(NN), .N_INPUTS(NI), .DATA_W(DW), .FRAC_W(FW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .act_mode(act_mode),
    .in_base(in_base), .w_base(w_base), .out_base(out_base),
    .busy(busy), .done(done), .sat_flag(sat_flag), .state_o(state_dbg),
    .bram(bus.master)
  );

  // ---------------- BRAM model and scoreboard ----------------
  logic [31:0]   mem [MEM_N];
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_a_q[$];
  logic [31:0]   got_q[$];
  logic [AW-1:0] got_a_q[$];
  int n_checks = 0, n_fail = 0, done_cnt = 0, acc_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      bus.bram_data_in <= '0;
    end else if (bus.bram_enable) begin
      bus.bram_data_in <= mem[bus.bram_data_addr];
      if (bus.bram_write_enable_bytes == 4'b0011) begin
        mem[bus.bram_data_addr][15:0] = bus.bram_data_out[15:0];
        got_q.push_back(bus.bram_data_out);
        got_a_q.push_back(bus.bram_data_addr);
      end
    end
  end

  // Bus monitor: done pulses, access count, write-cycle protocol.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (bus.bram_enable === 1'b1) acc_cnt++;
    if (bus.bram_write_enable_bytes !== 4'b0000) begin
      n_checks++;
      if (bus.bram_enable !== 1'b1 || bus.bram_write_enable_bytes !== 4'b0011 ||
          bus.bram_data_out[31:16] !== 16'h0) begin
        n_fail++;
        $display("FAIL bram_write_protocol: en=%b we=%b data=%h, required en=1 we=0011 upper 16 bits 0",
                 bus.bram_enable, bus.bram_write_enable_bytes, bus.bram_data_out);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] wrap(input int v);
    return AW'(v);
  endfunction

  function automatic longint sx(input logic [31:0] w);
    logic signed [DW-1:0] v;
    v = w[DW-1:0];
    return longint'(v);
  endfunction

  task automatic model_run(input bit act, input logic [AW-1:0] ib, wb, ob, output bit sat);
    longint acc, r;
    sat = 1'b0;
    for (int n = 0; n < NN; n++) begin
      acc = 0;
      if (BIAS) acc = sx(mem[wrap(int'(wb) + n * STRIDE + NI)]) * (longint'(1) << FW);
      for (int i = 0; i < NI; i++)
        acc += sx(mem[wrap(int'(ib) + i)]) * sx(mem[wrap(int'(wb) + n * STRIDE + i)]);
      r = acc >>> FW;
      if (r > 32767) begin r = 32767; sat = 1'b1; end
      else if (r < -32768) begin r = -32768; sat = 1'b1; end
      if (act) r = (r < 0) ? 0 : r;
      else     r = (r >= 0) ? (longint'(1) << FW) : 0;
      exp_q.push_back(32'(r));
      exp_a_q.push_back(wrap(int'(ob) + n));
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic poke(input int a, input logic [15:0] v);
    mem[wrap(a)] = {16'($urandom), v};
  endtask

  function automatic logic [15:0] rnd_val(input bit wide);
    if (wide) return 16'($urandom);
    return 16'($urandom_range(0, 2047) - 1024);
  endfunction

  // One full run: model, start pulse, bounded wait for done, scoreboard.
  // inject pulses start (with altered config) while busy and in the done cycle.
  task automatic run(input bit act, input logic [AW-1:0] ib, wb, ob, input bit inject,
                     output int cycles, output bit exp_sat, output bit sat_early);
    exp_q.delete(); exp_a_q.delete(); got_q.delete(); got_a_q.delete();
    model_run(act, ib, wb, ob, exp_sat);
    @(negedge clk);
    act_mode = act; in_base = ib; w_base = wb; out_base = ob; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cycles = 1; sat_early = sat_flag;
    while (done !== 1'b1 && cycles < 2000) begin
      if (inject && (cycles == 3 || cycles == RUN_LEN / 2)) begin
        start = 1'b1; act_mode = ~act; in_base = ib + AW'(37); w_base = wb + AW'(5);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: no done after %0d cycles, required %0d", cycles, RUN_LEN);
    end
    if (inject) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b the cycle after done, required 0 0", done, busy);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL write_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [31:0] g, e;
      logic [AW-1:0] ga, ea;
      g = got_q.pop_front(); e = exp_q.pop_front();
      ga = got_a_q.pop_front(); ea = exp_a_q.pop_front();
      n_checks++;
      if (g !== e || ga !== ea) begin
        n_fail++;
        $display("FAIL write_data: got %h @%0d, required %h @%0d", g, ga, e, ea);
      end
    end
  endtask

  task automatic check_run(input string name, input int cycles, input bit exp_sat);
    n_checks++;
    if (cycles !== RUN_LEN) begin
      n_fail++;
      $display("FAIL %s_run_length: got %0d cycles, required %0d", name, cycles, RUN_LEN);
    end
    n_checks++;
    if (sat_flag !== exp_sat) begin
      n_fail++;
      $display("FAIL %s_sat_flag: got %b, required %b", name, sat_flag, exp_sat);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b sat=%b, required 0 0 0", busy, done, sat_flag);
    end
    n_checks++;
    if (bus.bram_enable !== 1'b0 || bus.bram_write_enable_bytes !== 4'h0 ||
        bus.bram_data_addr !== '0 || bus.bram_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bram: en=%b we=%h addr=%h data=%h, required all 0", bus.bram_enable,
               bus.bram_write_enable_bytes, bus.bram_data_addr, bus.bram_data_out);
    end
    n_checks++;
    if (state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required IDLE", state_dbg);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || acc_cnt !== 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b accesses=%0d, required 0 0", busy, acc_cnt);
    end
  endtask

  task automatic test_basic();
    int cyc; bit es, se;
    for (int i = 0; i < NI; i++) poke(i, 16'h0100);
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++)
        poke(16 + n * STRIDE + i, (n == 0) ? 16'h0100 : (n == 1) ? 16'hFF00 : rnd_val(1'b0));
      if (BIAS) poke(16 + n * STRIDE + NI, 16'h0000);
    end
    run(ACT_STEP, 9'd0, 9'd16, 9'd64, 1'b0, cyc, es, se);
    check_run("step", cyc, es);
    n_checks++;
    if (mem[64][15:0] !== 16'h0100 || mem[65][15:0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL step_outputs: n0=%h n1=%h, required 0100 0000", mem[64][15:0], mem[65][15:0]);
    end
    run(ACT_RELU, 9'd0, 9'd16, 9'd64, 1'b0, cyc, es, se);
    check_run("relu", cyc, es);
    n_checks++;
    if (mem[64][15:0] !== 16'h0800 || mem[65][15:0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL relu_outputs: n0=%h n1=%h, required 0800 0000", mem[64][15:0], mem[65][15:0]);
    end
  endtask

  task automatic test_saturation();
    int cyc; bit es, se;
    for (int i = 0; i < NI; i++) poke(100 + i, 16'h7FFF);
    for (int i = 0; i < NN * STRIDE; i++) poke(120 + i, 16'h7FFF);
    run(ACT_RELU, 9'd100, 9'd120, 9'd200, 1'b0, cyc, es, se);
    check_run("sat", cyc, es);
    n_checks++;
    if (mem[200][15:0] !== 16'h7FFF || sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_value: out=%h sat=%b, required 7fff 1", mem[200][15:0], sat_flag);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold: got %b while idle, required 1", sat_flag);
    end
    for (int i = 0; i < NI; i++) poke(100 + i, 16'h0010);
    for (int i = 0; i < NN * STRIDE; i++) poke(120 + i, 16'h0010);
    run(ACT_RELU, 9'd100, 9'd120, 9'd200, 1'b0, cyc, es, se);
    n_checks++;
    if (se !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear_on_start: got %b after start, required 0", se);
    end
    check_run("nosat", cyc, es);
  endtask

  task automatic test_bias();
`ifdef NEURON_LAYER_BIAS_EN
    int cyc; bit es, se;
    for (int i = 0; i < NI; i++) poke(300 + i, rnd_val(1'b1));
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++) poke(320 + n * STRIDE + i, 16'h0000);
      poke(320 + n * STRIDE + NI, 16'h0200);
    end
    run(ACT_RELU, 9'd300, 9'd320, 9'd380, 1'b0, cyc, es, se);
    check_run("bias", cyc, es);
    n_checks++;
    if (cyc !== 53 || mem[380][15:0] !== 16'h0200 || mem[383][15:0] !== 16'h0200) begin
      n_fail++;
      $display("FAIL bias_outputs: cycles=%0d n0=%h n3=%h, required 53 0200 0200",
               cyc, mem[380][15:0], mem[383][15:0]);
    end
`endif
  endtask

  task automatic test_random();
    int cyc; bit es, se, wide, act;
    logic [AW-1:0] ib, wb, ob;
    for (int r = 0; r < 8; r++) begin
      ib = AW'($urandom_range(0, MEM_N - 1));
      wb = ib + AW'(16);
      ob = wb + AW'(48);
      wide = (r % 3 == 2);
      act = 1'($urandom_range(0, 1));
      for (int i = 0; i < NI; i++) poke(int'(ib) + i, rnd_val(wide));
      for (int i = 0; i < NN * STRIDE; i++) poke(int'(wb) + i, rnd_val(wide));
      run(act, ib, wb, ob, 1'b0, cyc, es, se);
      check_run("random", cyc, es);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, a0, d0; bit es, se;
    for (int i = 0; i < NI; i++) poke(i, rnd_val(1'b0));
    for (int i = 0; i < NN * STRIDE; i++) poke(16 + i, rnd_val(1'b0));
    @(negedge clk);
    act_mode = ACT_RELU; in_base = 9'd0; w_base = 9'd16; out_base = 9'd64; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < (NI + 1) + 2 * (STRIDE + 2) + 2) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (state_dbg !== MAC || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run_state: state=%0d busy=%b, required MAC 1", state_dbg, busy);
    end
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus.bram_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_immediate: busy=%b en=%b, required 0 0", busy, bus.bram_enable);
    end
    a0 = acc_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (acc_cnt !== a0 || done_cnt !== d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: accesses=%0d done=%0d busy=%b, required %0d %0d 0",
               acc_cnt, done_cnt, busy, a0, d0);
    end
    run(ACT_RELU, 9'd0, 9'd16, 9'd64, 1'b0, cyc, es, se);
    check_run("after_abort", cyc, es);
  endtask

  task automatic test_back_to_back();
    int cyc, d0; bit es, se;
    for (int i = 0; i < NI; i++) poke(400 + i, rnd_val(1'b0));
    for (int i = 0; i < NN * STRIDE; i++) poke(420 + i, rnd_val(1'b0));
    d0 = done_cnt;
    run(ACT_STEP, 9'd400, 9'd420, 9'd480, 1'b1, cyc, es, se);
    check_run("ignored_start", cyc, es);
    repeat (40) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL one_done_per_start: got %0d pulses busy=%b, required 1 0", done_cnt - d0, busy);
    end
    run(ACT_RELU, 9'd400, 9'd420, 9'd480, 1'b0, cyc, es, se);
    check_run("b2b", cyc, es);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int a = 0; a < MEM_N; a++) mem[a] = $urandom;
    test_reset();
    test_basic();
    test_saturation();
    test_bias();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
